// File: rtl/light_controller_pkg.sv
// rtl/light_controller_pkg.sv - lamp colour codes and controller state type shared by the intersection controller
package light_controller_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'd0;
   localparam logic [1:0] LIGHT_YELLOW = 2'd1;
   localparam logic [1:0] LIGHT_GREEN  = 2'd3;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2
   } light_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting after the last grant, ending on it
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_last,
   output logic [$clog2(N)-1:0] o_grant,
   output logic                 o_valid
);

   localparam int IDX_W = $clog2(N);

   int               w_k;
   logic [IDX_W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_grant = i_last;
      o_valid = 1'b0;
      w_k     = 0;
      w_idx   = '0;
      for (int i = N; i >= 1; i--) begin
         w_k   = (int'(i_last) + i) % N;
         w_idx = IDX_W'(w_k);
         if (i_req[w_idx]) begin
            o_grant = w_idx;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_light_controller.sv
// rtl/multi_light_controller.sv - N-approach actuated intersection controller: request latches, round-robin
// green grant, green/yellow/all-red sequencing and registered lamp decode
module multi_light_controller
   import light_controller_pkg::*;
#(
   parameter int NUM_APPROACHES = 4,
   parameter int CNT_W          = 8,
   parameter int MIN_GREEN      = 10,
   parameter int MAX_GREEN      = 40,
   parameter int YELLOW_TIME    = 4,
   parameter int ALL_RED_TIME   = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_APPROACHES-1:0]       car_has_arrived,
   input  logic                            street_light_controller,
   output logic [2*NUM_APPROACHES-1:0]     set_light_color,
   output logic [$clog2(NUM_APPROACHES)-1:0] active_approach
);

   localparam int IDX_W = $clog2(NUM_APPROACHES);
   localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALL_RED_TIME - 1);

   light_state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]            r_timer, w_timer_nxt, w_timer_inc;
   logic [NUM_APPROACHES-1:0]   r_req, w_req_nxt;
   logic [IDX_W-1:0]            r_active, w_active_nxt;
   logic [2*NUM_APPROACHES-1:0] r_color, w_color_nxt;

   logic [NUM_APPROACHES-1:0]   w_eff, w_own;
   logic [IDX_W-1:0]            w_grant;
   logic                        w_grant_vld;
   logic                        w_contested;

   assign w_eff       = r_req | car_has_arrived;
   assign w_own       = {{(NUM_APPROACHES-1){1'b0}}, 1'b1} << r_active;
   assign w_contested = |(w_eff & ~w_own);
   assign w_timer_inc = (r_timer == {CNT_W{1'b1}}) ? r_timer : r_timer + 1'b1;

   rr_arbiter #(
      .N(NUM_APPROACHES)
   ) u_arbiter (
      .i_req   (w_eff),
      .i_last  (r_active),
      .o_grant (w_grant),
      .o_valid (w_grant_vld)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = w_timer_inc;
      w_active_nxt = r_active;
      case (r_state)
         ALL_RED: begin
            if (r_timer >= AR_LIM && street_light_controller && w_grant_vld) begin
               w_state_nxt  = GREEN;
               w_timer_nxt  = '0;
               w_active_nxt = w_grant;
            end
         end
         GREEN: begin
            // Losing the enable ends green at once, ahead of the minimum-green floor.
            if (!street_light_controller ||
                (r_timer >= MIN_LIM && w_contested &&
                 (!car_has_arrived[r_active] || r_timer >= MAX_LIM))) begin
               w_state_nxt = YELLOW;
               w_timer_nxt = '0;
            end
         end
         YELLOW: begin
            if (r_timer >= YEL_LIM) begin
               w_state_nxt = ALL_RED;
               w_timer_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ALL_RED;
            w_timer_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_req_nxt = r_req | car_has_arrived;
      if (r_state == GREEN)
         w_req_nxt[r_active] = r_req[r_active];
      if (r_state != GREEN && w_state_nxt == GREEN)
         w_req_nxt[w_active_nxt] = 1'b0;
   end

   // Lamps decode from the next state so they change on the same edge as the FSM.
   always_comb begin
      w_color_nxt = '0;
      for (int i = 0; i < NUM_APPROACHES; i++) begin
         w_color_nxt[2*i +: 2] = LIGHT_RED;
         if (IDX_W'(i) == w_active_nxt) begin
            if (w_state_nxt == GREEN)
               w_color_nxt[2*i +: 2] = LIGHT_GREEN;
            else if (w_state_nxt == YELLOW)
               w_color_nxt[2*i +: 2] = LIGHT_YELLOW;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ALL_RED;
         r_timer  <= '0;
         r_req    <= '0;
         r_active <= '0;
         r_color  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_req    <= w_req_nxt;
         r_active <= w_active_nxt;
         r_color  <= w_color_nxt;
      end
   end

   assign set_light_color = r_color;
   assign active_approach = r_active;

endmodule

// File: tb/tb_multi_light_controller.sv
// tb/tb_multi_light_controller.sv - scoreboard bench for multi_light_controller (N=4, min 4, max 8, yellow 2, all-red 2)
module tb_multi_light_controller;

   logic       clk;
   logic       rst;
   logic [3:0] car;
   logic       slc;
   logic [7:0] color;
   logic [1:0] act;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] col;
      logic [1:0] act;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   multi_light_controller #(
      .NUM_APPROACHES (4),
      .CNT_W          (8),
      .MIN_GREEN      (4),
      .MAX_GREEN      (8),
      .YELLOW_TIME    (2),
      .ALL_RED_TIME   (2)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .car_has_arrived         (car),
      .street_light_controller (slc),
      .set_light_color         (color),
      .active_approach         (act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs expected after the next edge.
   task automatic cyc(input logic [3:0] c, input logic s, input logic [7:0] ec, input logic [1:0] ea,
                      input string tag);
      exp_t e;
      car   = c;
      slc   = s;
      e.col = ec;
      e.act = ea;
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check_val({tag, "_col"}, 32'(color), 32'h00);
      check_val({tag, "_act"}, 32'(act), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_val({e.tag, "_col"}, 32'(color), 32'(e.col));
         check_val({e.tag, "_act"}, 32'(act), 32'(e.act));
      end
   end

   // One green phase of a contested approach with idle own sensor: 4 green, 2 yellow, 2 all-red.
   task automatic contested_phase(input int a, input string tag);
      logic [7:0] g;
      logic [7:0] y;
      g = 8'h03 << (2 * a);
      y = 8'h01 << (2 * a);
      for (int i = 0; i < 3; i++) cyc(4'h0, 1'b1, g, 2'(a), {tag, "_green"});
      for (int i = 0; i < 2; i++) cyc(4'h0, 1'b1, y, 2'(a), {tag, "_yellow"});
      for (int i = 0; i < 2; i++) cyc(4'h0, 1'b1, 8'h00, 2'(a), {tag, "_allred"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      car = 4'h0;
      slc = 1'b1;
      do_reset("reset");

      for (int i = 0; i < 10; i++) cyc(4'h0, 1'b1, 8'h00, 2'd0, "idle");

      cyc(4'b0100, 1'b1, 8'h30, 2'd2, "grant2");
      for (int i = 0; i < 5; i++) cyc(4'h0, 1'b1, 8'h30, 2'd2, "hold2");

      cyc(4'b0001, 1'b1, 8'h10, 2'd2, "y2");
      cyc(4'b0000, 1'b1, 8'h10, 2'd2, "y2");
      cyc(4'b0000, 1'b1, 8'h00, 2'd2, "ar2");
      cyc(4'b0000, 1'b1, 8'h00, 2'd2, "ar2");
      cyc(4'b0000, 1'b1, 8'h03, 2'd0, "grant0");

      cyc(4'b0100, 1'b1, 8'h03, 2'd0, "min0");
      cyc(4'b0000, 1'b1, 8'h03, 2'd0, "min0");
      cyc(4'b0000, 1'b1, 8'h03, 2'd0, "min0");
      cyc(4'b0000, 1'b1, 8'h01, 2'd0, "y0");
      cyc(4'b0000, 1'b1, 8'h01, 2'd0, "y0");
      cyc(4'b0000, 1'b1, 8'h00, 2'd0, "ar0");
      cyc(4'b0000, 1'b1, 8'h00, 2'd0, "ar0");
      cyc(4'b0000, 1'b1, 8'h30, 2'd2, "regrant2");

      for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b1, 8'h30, 2'd2, "min2");
      cyc(4'b0010, 1'b1, 8'h10, 2'd2, "y2b");
      cyc(4'b0010, 1'b1, 8'h10, 2'd2, "y2b");
      cyc(4'b0010, 1'b1, 8'h00, 2'd2, "ar2b");
      cyc(4'b0010, 1'b1, 8'h00, 2'd2, "ar2b");
      cyc(4'b0010, 1'b1, 8'h0C, 2'd1, "grant1");
      cyc(4'b1010, 1'b1, 8'h0C, 2'd1, "max1");
      for (int i = 0; i < 6; i++) cyc(4'b0010, 1'b1, 8'h0C, 2'd1, "max1");
      cyc(4'b0010, 1'b1, 8'h04, 2'd1, "y1");
      cyc(4'b0000, 1'b1, 8'h04, 2'd1, "y1");
      cyc(4'b0000, 1'b1, 8'h00, 2'd1, "ar1");
      cyc(4'b0000, 1'b1, 8'h00, 2'd1, "ar1");
      cyc(4'b0000, 1'b1, 8'hC0, 2'd3, "grant3");

      do_reset("reset2");
      cyc(4'b0000, 1'b1, 8'h00, 2'd0, "clear");
      cyc(4'b0010, 1'b1, 8'h0C, 2'd1, "rr_g1");
      cyc(4'b0000, 1'b0, 8'h04, 2'd1, "slc_abort");
      cyc(4'b0000, 1'b0, 8'h04, 2'd1, "slc_y");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "slc_ar");
      cyc(4'b1111, 1'b0, 8'h00, 2'd1, "all_arrive");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "blocked");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "blocked");
      cyc(4'b0000, 1'b1, 8'h30, 2'd2, "rr_2");
      contested_phase(2, "rr2");
      cyc(4'b0000, 1'b1, 8'hC0, 2'd3, "rr_3");
      contested_phase(3, "rr3");
      cyc(4'b0000, 1'b1, 8'h03, 2'd0, "rr_0");
      contested_phase(0, "rr0");
      cyc(4'b0000, 1'b1, 8'h0C, 2'd1, "rr_1");
      for (int i = 0; i < 3; i++) cyc(4'h0, 1'b1, 8'h0C, 2'd1, "hold1");

      cyc(4'b0000, 1'b0, 8'h04, 2'd1, "slc_off");
      cyc(4'b0000, 1'b0, 8'h04, 2'd1, "slc_off_y");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "slc_off_ar");
      cyc(4'b0001, 1'b0, 8'h00, 2'd1, "slc_latch");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "slc_hold");
      cyc(4'b0000, 1'b0, 8'h00, 2'd1, "slc_hold");
      cyc(4'b0000, 1'b1, 8'h03, 2'd0, "slc_resume");
      cyc(4'b0010, 1'b1, 8'h03, 2'd0, "pre_rst");

      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_col", 32'(color), 32'h00);
      check_val("async_rst_act", 32'(act), 32'h0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(4'h0, 1'b1, 8'h00, 2'd0, "req_lost");

      check_val("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_light_controller.md
# multi_light_controller

Parametrised N-approach traffic intersection controller; successor to the single-approach light controller. Latches car arrivals per approach, grants green to one approach at a time by round-robin, and sequences green → yellow → all-red clearance using cycle counters. Actuated green (minimum, extension, maximum) is supported. A global `street_light_controller` enable can veto or terminate green. Sits between the car sensors and the per-approach lamp drivers.

## Interface
- `NUM_APPROACHES`, 4: number of approaches, ≥2.
- `CNT_W`, 8: timer width; must hold `MAX_GREEN`.
- `MIN_GREEN`, 10: minimum green cycles, ≥1.
- `MAX_GREEN`, 40: maximum green cycles when contested, ≥`MIN_GREEN`.
- `YELLOW_TIME`, 4: yellow cycles, ≥1.
- `ALL_RED_TIME`, 2: all-red clearance cycles, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `car_has_arrived` in `NUM_APPROACHES`: per-approach car sensor, level, 1 = car present.
- `street_light_controller` in 1: 1 = green allowed, 0 = green forbidden.
- `set_light_color` out 2×`NUM_APPROACHES`: lamp command; slice `[2i+1:2i]` is approach i. Encoding: 0 = red, 1 = yellow, 3 = green.
- `active_approach` out `$clog2(NUM_APPROACHES)`: index of the last granted approach.

## Operation
- Reset (async assert): state `ALL_RED`, timer 0, `req` 0, `active_approach` 0, every `set_light_color` slice 0 (red).
- Request latch `req[i]`:
  - Set on a clock edge where `car_has_arrived[i]`=1.
  - Cleared on the edge where approach i enters `GREEN`.
  - Not set while i is the active approach in `GREEN`.
- Effective request: `eff = req | car_has_arrived`.
- `ALL_RED`:
  - Timer increments, saturating.
  - Transition to `GREEN` when all of these hold:
    - timer ≥ `ALL_RED_TIME`-1;
    - `street_light_controller`=1;
    - any `eff` bit is set.
  - Grant goes to the first set `eff` bit searching `active_approach`+1, +2, … mod N, ending with `active_approach` itself.
  - Timer resets to 0 on grant.
- `GREEN` (approach a): timer increments, saturating at all-ones. Go to `YELLOW` (timer 0) when either condition holds:
  - `street_light_controller`=0. This is immediate and overrides `MIN_GREEN`.
  - timer ≥ `MIN_GREEN`-1, some `eff[j]` with j≠a is set, and either `car_has_arrived[a]`=0 or timer ≥ `MAX_GREEN`-1.
- Uncontested green holds indefinitely.
- `YELLOW`: after `YELLOW_TIME` cycles, go to `ALL_RED` with timer 0. Yellow is never aborted.
- Output slices:
  - Approach a: 3 in `GREEN`, 1 in `YELLOW`.
  - All other slices, and all slices in `ALL_RED`: 0.
  - At most one slice is non-zero at any time.

## Timing
- All outputs are registered and change on the same edge as the state.
- Request to green: 1 cycle, when the all-red clearance has already elapsed. An arrival sampled at edge k drives green on the outputs after edge k.
- Green duration, contested with own sensor idle: exactly `MIN_GREEN` cycles.
- Green duration, contested with own sensor held: `MAX_GREEN` cycles.
- Yellow lasts exactly `YELLOW_TIME` cycles; all-red lasts at least `ALL_RED_TIME` cycles.
- Simultaneous arrivals on several approaches: round-robin order from `active_approach`+1. Every latched request is served within N-1 intervening grants.
- Deasserting `street_light_controller` during `GREEN` forces yellow on the next edge. During `ALL_RED` it blocks new grants; requests stay latched.
- `rst` mid-cycle: all lamps go red immediately (asynchronously); pending requests are lost.

## Structure
- Package `light_controller_pkg`:
  - Color constants `LIGHT_RED`=2'd0, `LIGHT_YELLOW`=2'd1, `LIGHT_GREEN`=2'd3.
  - State enum {`ALL_RED`, `GREEN`, `YELLOW`}.
- Sub-module `rr_arbiter`: combinational next-requester search, parametrised by N. Inputs are the request vector and the last grant index; outputs are the grant index and a valid flag.
- Top level holds the FSM, the timer, the request latches and the output decode.

## Test plan
All scenarios use N=4, `MIN_GREEN`=4, `MAX_GREEN`=8, `YELLOW_TIME`=2, `ALL_RED_TIME`=2.
- Reset, then idle for 10 cycles → `set_light_color`=8'h00 throughout, `active_approach`=0.
- After clearance, pulse `car_has_arrived`=4'b0100 for 1 cycle → next edge gives 8'h30, held indefinitely with no other requests.
- While approach 2 is green, approach 0 arrives and approach 2's sensor is low → green lasts 4 cycles total, then 8'h10 for 2 cycles, 8'h00 for 2 cycles, then 8'h03.
- Approach 1 sensor held high while approach 3 requests → approach 1 green lasts exactly 8 cycles, then yellow, then approach 3.
- 4'b1111 arrives in `ALL_RED` with `active_approach`=1 → grant order 2, 3, 0, 1.
- `street_light_controller`=0 at green cycle 1 → yellow on the next edge. Held 0: stays all-red with requests latched. Returned to 1: grant resumes.
